// File: rtl/hoplite_pe_nic.sv
// hoplite_pe_nic: network interface between a PE's memory-mapped message ports
// and its Hoplite router port.
// TX side is store-and-forward: words collect in a FIFO and become visible to
// the router only once the PE commits the packet. RX side buffers ejected flits
// for the PE once the PE has armed the path.
// Optional build macro HOPLITE_NIC_STATS_EN adds tx_flit_count / rx_flit_count.
module hoplite_pe_nic #(
    parameter int COORD_BITS = 1,
    parameter int X_COORD    = 0,
    parameter int Y_COORD    = 0,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 8,
    localparam int FLIT_W    = 33 + 2 * COORD_BITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [COORD_BITS-1:0] x_coord_out,
    input  logic                  x_coord_out_valid,
    input  logic [COORD_BITS-1:0] y_coord_out,
    input  logic                  y_coord_out_valid,
    input  logic [31:0]           message_out,
    input  logic                  message_out_valid,
    input  logic                  packet_out_complete,
    output logic [31:0]           message_in,
    output logic                  message_in_valid,
    input  logic                  message_in_read,
    input  logic                  message_in_ready,
    output logic [FLIT_W-1:0]     inj_flit,
    output logic                  inj_valid,
    input  logic                  inj_ready,
    input  logic [FLIT_W-1:0]     ej_flit,
    input  logic                  ej_valid,
    output logic                  ej_ready,
    output logic                  tx_overflow,
    output logic                  rx_underflow,
    output logic                  rx_misroute
`ifdef HOPLITE_NIC_STATS_EN
    ,
    output logic [31:0]           tx_flit_count,
    output logic [31:0]           rx_flit_count
`endif
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [COORD_BITS-1:0] OWN_X = COORD_BITS'(X_COORD);
    localparam logic [COORD_BITS-1:0] OWN_Y = COORD_BITS'(Y_COORD);

    // ---------------- destination latches ----------------
    logic [COORD_BITS-1:0] dest_x_reg, dest_y_reg, dest_x_eff, dest_y_eff;

    // A coordinate update in the same cycle as a word applies to that word.
    assign dest_x_eff = x_coord_out_valid ? x_coord_out : dest_x_reg;
    assign dest_y_eff = y_coord_out_valid ? y_coord_out : dest_y_reg;

    // Hold the most recent destination written by the PE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dest_x_reg <= '0;
            dest_y_reg <= '0;
        end else begin
            dest_x_reg <= dest_x_eff;
            dest_y_reg <= dest_y_eff;
        end
    end

    // ---------------- TX FIFO ----------------
    // Body {dest_x, dest_y, data} lives in a plain array; the per-entry last
    // bit is kept in flops because commit has to set it on an already-written
    // entry.
    logic [FLIT_W-2:0] tx_mem [TX_DEPTH];
    logic [TX_DEPTH-1:0] tx_last;
    logic [TX_AW:0] tx_wr_ptr_reg, tx_commit_ptr_reg, tx_rd_ptr_reg, tx_wr_prev;
    logic [TX_AW-1:0] tx_wr_idx, tx_prev_idx, tx_rd_idx;
    logic tx_full, tx_write, tx_open, tx_pop, tx_mark_prev;

    assign tx_wr_idx    = tx_wr_ptr_reg[TX_AW-1:0];
    assign tx_wr_prev   = tx_wr_ptr_reg - 1'b1;
    assign tx_prev_idx  = tx_wr_prev[TX_AW-1:0];
    assign tx_rd_idx    = tx_rd_ptr_reg[TX_AW-1:0];
    assign tx_full      = (tx_wr_ptr_reg - tx_rd_ptr_reg) == TX_FULL_CNT;
    assign tx_write     = message_out_valid & ~tx_full;
    assign tx_open      = tx_wr_ptr_reg != tx_commit_ptr_reg;
    assign tx_mark_prev = packet_out_complete & ~tx_write & tx_open;
    assign inj_valid    = tx_rd_ptr_reg != tx_commit_ptr_reg;
    assign tx_pop       = inj_valid & inj_ready;
    assign inj_flit     = {tx_last[tx_rd_idx], tx_mem[tx_rd_idx]};

    // Store the flit body of each accepted word.
    always_ff @(posedge clk) begin
        if (tx_write) begin
            tx_mem[tx_wr_idx] <= {dest_x_eff, dest_y_eff, message_out};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < TX_DEPTH; gi++) begin : g_tx_last
            logic last_reg;
            // A fresh word is last only if committed on arrival; a commit
            // without a word marks the newest stored word instead.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    last_reg <= 1'b0;
                end else if (tx_write && tx_wr_idx == TX_AW'(gi)) begin
                    last_reg <= packet_out_complete;
                end else if (tx_mark_prev && tx_prev_idx == TX_AW'(gi)) begin
                    last_reg <= 1'b1;
                end
            end
            assign tx_last[gi] = last_reg;
        end
    endgenerate

    // Advance write/commit/read pointers and flag dropped words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wr_ptr_reg     <= '0;
            tx_commit_ptr_reg <= '0;
            tx_rd_ptr_reg     <= '0;
            tx_overflow       <= 1'b0;
        end else begin
            if (tx_write) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (packet_out_complete && tx_write) tx_commit_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            else if (tx_mark_prev) tx_commit_ptr_reg <= tx_wr_ptr_reg;
            if (tx_pop) tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
            if (message_out_valid && tx_full) tx_overflow <= 1'b1;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [31:0] rx_mem [RX_DEPTH];
    logic [RX_AW:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic rx_armed_reg, rx_full, rx_empty, rx_accept, rx_hit, rx_push, rx_pop;
    logic ej_last_unused;

    assign ej_last_unused   = ej_flit[FLIT_W-1];
    assign rx_full          = (rx_wr_ptr_reg - rx_rd_ptr_reg) == RX_FULL_CNT;
    assign rx_empty         = rx_wr_ptr_reg == rx_rd_ptr_reg;
    assign ej_ready         = rx_armed_reg & ~rx_full;
    assign rx_accept        = ej_valid & ej_ready;
    assign rx_hit           = (ej_flit[FLIT_W-2 -: COORD_BITS] == OWN_X) &&
                              (ej_flit[FLIT_W-2-COORD_BITS -: COORD_BITS] == OWN_Y);
    assign rx_push          = rx_accept & rx_hit;
    assign rx_pop           = message_in_read & ~rx_empty;
    assign message_in_valid = ~rx_empty;
    assign message_in       = rx_mem[rx_rd_ptr_reg[RX_AW-1:0]];

    // Store payload of correctly addressed ejected flits.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr_reg[RX_AW-1:0]] <= ej_flit[31:0];
        end
    end

    // RX pointers, arming and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_armed_reg  <= 1'b0;
            rx_underflow  <= 1'b0;
            rx_misroute   <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop) rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            if (message_in_ready) rx_armed_reg <= 1'b1;
            if (message_in_read && rx_empty) rx_underflow <= 1'b1;
            if (rx_accept && !rx_hit) rx_misroute <= 1'b1;
        end
    end

`ifdef HOPLITE_NIC_STATS_EN
    // Free-running handshake counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_flit_count <= '0;
            rx_flit_count <= '0;
        end else begin
            if (tx_pop) tx_flit_count <= tx_flit_count + 32'd1;
            if (rx_accept) rx_flit_count <= rx_flit_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hoplite_pe_nic.sv
// Bench for hoplite_pe_nic (node (0,0), 1-bit coords, depth 8 FIFOs).
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a queue-based packet model.
module tb_hoplite_pe_nic;
    localparam int FW    = 35;
    localparam int DEPTH = 8;
    typedef logic [FW-1:0] flit_t;

    logic        clk, reset_n;
    logic        x_coord_out, x_coord_out_valid, y_coord_out, y_coord_out_valid;
    logic [31:0] message_out, message_in;
    logic        message_out_valid, packet_out_complete, message_in_valid;
    logic        message_in_read, message_in_ready;
    flit_t       inj_flit, ej_flit;
    logic        inj_valid, inj_ready, ej_valid, ej_ready;
    logic        tx_overflow, rx_underflow, rx_misroute;
`ifdef HOPLITE_NIC_STATS_EN
    logic [31:0] tx_flit_count, rx_flit_count;
`endif

    hoplite_pe_nic dut (
        .clk(clk), .reset_n(reset_n),
        .x_coord_out(x_coord_out), .x_coord_out_valid(x_coord_out_valid),
        .y_coord_out(y_coord_out), .y_coord_out_valid(y_coord_out_valid),
        .message_out(message_out), .message_out_valid(message_out_valid),
        .packet_out_complete(packet_out_complete),
        .message_in(message_in), .message_in_valid(message_in_valid),
        .message_in_read(message_in_read), .message_in_ready(message_in_ready),
        .inj_flit(inj_flit), .inj_valid(inj_valid), .inj_ready(inj_ready),
        .ej_flit(ej_flit), .ej_valid(ej_valid), .ej_ready(ej_ready),
        .tx_overflow(tx_overflow), .rx_underflow(rx_underflow), .rx_misroute(rx_misroute)
`ifdef HOPLITE_NIC_STATS_EN
        , .tx_flit_count(tx_flit_count), .rx_flit_count(rx_flit_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    flit_t       cq[$];   // committed flits awaiting injection
    flit_t       oq[$];   // open packet, not yet committed
    logic [31:0] rxq[$];
    bit          m_armed, m_ovf, m_unf, m_mis;
    logic        m_dx, m_dy;
    int unsigned m_tx, m_rx;

    // ---------------- drive variables ----------------
    bit          d_xv, d_yv, d_mv, d_pc, d_rd, d_arm, d_ir, d_ev;
    logic        d_xc, d_yc;
    logic [31:0] d_md;
    flit_t       d_ef;

    task automatic model_clear();
        cq.delete(); oq.delete(); rxq.delete();
        m_armed = 0; m_ovf = 0; m_unf = 0; m_mis = 0;
        m_dx = 0; m_dy = 0; m_tx = 0; m_rx = 0;
    endtask

    task automatic check_outputs();
        check("inj_valid", 64'(inj_valid), 64'(cq.size() > 0));
        if (cq.size() > 0) check("inj_flit", 64'(inj_flit), 64'(cq[0]));
        check("ej_ready", 64'(ej_ready), 64'(m_armed && rxq.size() < DEPTH));
        check("msg_valid", 64'(message_in_valid), 64'(rxq.size() > 0));
        if (rxq.size() > 0) check("msg_data", 64'(message_in), 64'(rxq[0]));
        check("tx_overflow", 64'(tx_overflow), 64'(m_ovf));
        check("rx_underflow", 64'(rx_underflow), 64'(m_unf));
        check("rx_misroute", 64'(rx_misroute), 64'(m_mis));
`ifdef HOPLITE_NIC_STATS_EN
        check("tx_count", 64'(tx_flit_count), 64'(m_tx));
        check("rx_count", 64'(rx_flit_count), 64'(m_rx));
`endif
    endtask

    // One clock: check state at negedge, apply inputs, advance model, clock.
    task automatic cycle();
        bit    full_old, inj_now, rdy_now, accepted;
        logic  dx, dy;
        flit_t t;
        check_outputs();
        x_coord_out = d_xc; x_coord_out_valid = d_xv;
        y_coord_out = d_yc; y_coord_out_valid = d_yv;
        message_out = d_md; message_out_valid = d_mv;
        packet_out_complete = d_pc; message_in_read = d_rd;
        message_in_ready = d_arm; inj_ready = d_ir;
        ej_valid = d_ev; ej_flit = d_ef;

        full_old = (cq.size() + oq.size()) == DEPTH;
        inj_now  = cq.size() > 0;
        rdy_now  = m_armed && rxq.size() < DEPTH;
        dx = d_xv ? d_xc : m_dx;
        dy = d_yv ? d_yc : m_dy;
        if (inj_now && d_ir) begin
            void'(cq.pop_front());
            m_tx++;
        end
        if (d_mv) begin
            if (!full_old) oq.push_back({1'b0, dx, dy, d_md});
            else m_ovf = 1;
        end
        if (d_pc && oq.size() > 0) begin
            t = oq.pop_back();
            t[FW-1] = 1'b1;
            oq.push_back(t);
            foreach (oq[i]) cq.push_back(oq[i]);
            oq.delete();
        end
        m_dx = dx; m_dy = dy;
        if (d_rd) begin
            if (rxq.size() > 0) void'(rxq.pop_front());
            else m_unf = 1;
        end
        accepted = d_ev && rdy_now;
        if (accepted) begin
            m_rx++;
            if (d_ef[33:32] == 2'b00) rxq.push_back(d_ef[31:0]);
            else m_mis = 1;
        end
        if (d_arm) m_armed = 1;

        @(posedge clk);
        @(negedge clk);
        d_xv = 0; d_yv = 0; d_mv = 0; d_pc = 0; d_rd = 0; d_arm = 0;
        if (accepted) d_ev = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_clear();
        d_xv = 0; d_yv = 0; d_mv = 0; d_pc = 0; d_rd = 0; d_arm = 0; d_ir = 0; d_ev = 0;
        message_out_valid = 0; packet_out_complete = 0; message_in_read = 0;
        message_in_ready = 0; inj_ready = 0; ej_valid = 0;
        x_coord_out_valid = 0; y_coord_out_valid = 0;
        #1;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic rand_phase(input int n, input int p_msg, input int p_cmt,
                              input int p_ir, input int p_ev, input int p_rd);
        for (int k = 0; k < n; k++) begin
            d_xv = ($urandom % 100) < 10; d_xc = 1'($urandom);
            d_yv = ($urandom % 100) < 10; d_yc = 1'($urandom);
            d_mv = ($urandom % 100) < p_msg; d_md = $urandom;
            d_pc = ($urandom % 100) < p_cmt;
            d_ir = ($urandom % 100) < p_ir;
            d_rd = ($urandom % 100) < p_rd;
            d_arm = ($urandom % 100) < 3;
            if (!d_ev) begin
                d_ev = ($urandom % 100) < p_ev;
                d_ef = {1'($urandom), (($urandom % 100) < 15) ? 2'($urandom) : 2'b00, 32'($urandom)};
            end
            cycle();
        end
    endtask

    int cnt;

    initial begin
        d_xc = 0; d_yc = 0; d_md = 0; d_ef = '0;
        x_coord_out = 0; y_coord_out = 0; message_out = 0; ej_flit = '0;
        do_reset();
        cycle();

        // Two-word packet to (1,0); nothing visible before commit.
        d_xv = 1; d_xc = 1; d_yv = 1; d_yc = 0; d_mv = 1; d_md = 32'hA; cycle();
        d_mv = 1; d_md = 32'hB; cycle();
        check("t1_precommit", 64'(inj_valid), 64'd0);
        d_pc = 1; cycle();
        check("t1_flitA", 64'(inj_flit), 64'h2_0000_000A);
        d_ir = 1; cycle();
        check("t1_flitB", 64'(inj_flit), 64'h6_0000_000B);
        cycle(); cycle();

        // Three uncommitted words stay hidden for 50 cycles.
        for (int i = 0; i < 3; i++) begin d_mv = 1; d_md = 32'h100 + i; cycle(); end
        for (int i = 0; i < 50; i++) cycle();
        d_pc = 1; cycle();
        for (int i = 0; i < 5; i++) cycle();

        // Overflow: 9 words into a depth-8 FIFO.
        d_ir = 0;
        for (int i = 0; i < 9; i++) begin d_mv = 1; d_md = 32'h200 + i; cycle(); end
        check("ovf_flag", 64'(tx_overflow), 64'd1);
        d_pc = 1; cycle();
        d_ir = 1; cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (inj_valid) cnt++;
            cycle();
        end
        check("ovf_flits", 64'(cnt), 64'd8);

        // RX: unarmed path refuses, then delivers after arming.
        do_reset();
        d_ev = 1; d_ef = {3'b000, 32'h1234};
        for (int i = 0; i < 3; i++) cycle();
        check("rx_unarmed", 64'(ej_ready), 64'd0);
        d_arm = 1; cycle();
        cycle();
        check("rx_data", 64'(message_in), 64'h1234);
        d_rd = 1; cycle();
        check("rx_empty", 64'(message_in_valid), 64'd0);

        // Fill RX, then pop/push together, then drain and underflow.
        for (int i = 0; i < 8; i++) begin d_ev = 1; d_ef = {3'b000, 32'h300 + i}; cycle(); end
        check("rx_full", 64'(ej_ready), 64'd0);
        d_ev = 1; d_ef = {3'b000, 32'h400}; d_rd = 1; cycle();
        d_rd = 1; cycle();
        d_ev = 1; d_ef = {3'b000, 32'h401}; d_rd = 1; cycle();
        for (int i = 0; i < 10; i++) begin d_rd = 1; cycle(); end
        check("rx_unf", 64'(rx_underflow), 64'd1);

        // Misrouted flit is accepted but not delivered.
        d_ev = 1; d_ef = {3'b011, 32'h5555}; cycle();
        cycle();
        check("misroute", 64'(rx_misroute), 64'd1);
        check("mis_novalid", 64'(message_in_valid), 64'd0);

        // Randomized traffic, with a reset in the middle.
        do_reset();
        rand_phase(1500, 40, 10, 60, 40, 30);
        rand_phase(800, 80, 3, 20, 70, 10);
        do_reset();
        rand_phase(1500, 50, 20, 90, 50, 60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
